// File: rtl/letter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | letter_pkg : shared types and defaults for the letter pool         |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package letter_pkg;

    localparam int C_SLOTS_DEF        = 8;
    localparam int C_SPAWN_FRAMES_DEF = 30;
    localparam int C_X_BOTTOM_DEF     = 440;
    localparam int C_MAX_MISS_DEF     = 10;

    localparam logic [7:0] C_ASCII_UA = 8'h41;
    localparam logic [7:0] C_ASCII_UZ = 8'h5A;
    localparam logic [7:0] C_ASCII_LA = 8'h61;
    localparam logic [7:0] C_ASCII_LZ = 8'h7A;

    typedef struct packed {
        logic       active;
        logic [7:0] ch;
        logic [8:0] x;
        logic [9:0] y;
        logic [2:0] spd;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    function automatic logic [7:0] fold_upper(input logic [7:0] c);
        return ((c >= C_ASCII_LA) && (c <= C_ASCII_LZ)) ? (c - 8'h20) : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/letter_pool_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | letter_pool_if : control, generator, key and renderer signals      |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
interface letter_pool_if
    import letter_pkg::*;
#(
    parameter int SLOTS = C_SLOTS_DEF
);
    localparam int IDX_W = $clog2(SLOTS);

    logic             start;
    logic             frame_tick;
    logic [7:0]       gen_ch;
    logic [2:0]       gen_speed;
    logic [8:0]       gen_x;
    logic [9:0]       gen_y;
    logic             key_valid;
    logic [7:0]       key_ascii;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_active;
    logic [7:0]       rd_ch;
    logic [8:0]       rd_x;
    logic [9:0]       rd_y;
    logic [15:0]      score;
    logic [15:0]      miss;
    logic             running;
    logic             game_over;
    logic             hit_pulse;
    logic             miss_pulse;

    modport master (
        output start, frame_tick, gen_ch, gen_speed, gen_x, gen_y,
               key_valid, key_ascii, rd_idx,
        input  rd_active, rd_ch, rd_x, rd_y, score, miss,
               running, game_over, hit_pulse, miss_pulse
    );

    modport slave (
        input  start, frame_tick, gen_ch, gen_speed, gen_x, gen_y,
               key_valid, key_ascii, rd_idx,
        output rd_active, rd_ch, rd_x, rd_y, score, miss,
               running, game_over, hit_pulse, miss_pulse
    );

endinterface
`default_nettype wire

// File: rtl/slot_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slot_pick : index of the candidate with the largest key,           |
// |             lowest index on a tie | Revision : 1.0                 |
// +--------------------------------------------------------------------+
module slot_pick #(
    parameter int N     = 8,
    parameter int KEY_W = 9,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]            cand_i,
    input  logic [N-1:0][KEY_W-1:0] key_i,
    output logic                    found_o,
    output logic [IDX_W-1:0]        idx_o
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;
    logic [KEY_W-1:0] w_best;

    // Strict greater-than keeps the earlier (lower) index on equal keys.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_best  = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_i[i] && (!w_found || (key_i[i] > w_best))) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(i);
                w_best  = key_i[i];
            end
        end
    end

    assign found_o = w_found;
    assign idx_o   = w_idx;

endmodule
`default_nettype wire

// File: rtl/letter_pool.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | letter_pool : falling-letter table with spawn, move, hit and miss  |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module letter_pool
    import letter_pkg::*;
#(
    parameter int SLOTS        = C_SLOTS_DEF,
    parameter int SPAWN_FRAMES = C_SPAWN_FRAMES_DEF,
    parameter int X_BOTTOM     = C_X_BOTTOM_DEF,
    parameter int MAX_MISS     = C_MAX_MISS_DEF
) (
    input  wire          clk,
    input  wire          rst_n,
    letter_pool_if.slave bus
);

    localparam int IDX_W = $clog2(SLOTS);
    localparam int CNT_W = $clog2(SPAWN_FRAMES + 1);
    localparam int MC_W  = $clog2(SLOTS + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SPAWN_FRAMES - 1);
    localparam logic [9:0]       C_X_BOT    = 10'(X_BOTTOM);
    localparam logic [15:0]      C_MAX_MISS = 16'(MAX_MISS);

    state_t           state_q;
    slot_t            slots_q [SLOTS];
    slot_t            slots_d [SLOTS];
    logic [15:0]      score_q, score_d;
    logic [15:0]      miss_q, miss_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_pulse_q, miss_pulse_q, running_q, game_over_q;

    logic [7:0]                 w_key_up;
    logic                       w_key_ok;
    logic [SLOTS-1:0]           w_free, w_match;
    logic [SLOTS-1:0][8:0]      w_xs;
    logic [SLOTS-1:0][0:0]      w_zero_key;
    logic                       w_free_found, w_hit_found, w_spawn;
    logic [IDX_W-1:0]           w_free_idx, w_hit_idx;
    logic [MC_W-1:0]            w_miss_cnt;
    logic [16:0]                w_miss_sum;

    always_comb begin
        w_key_up = fold_upper(bus.key_ascii);
        w_key_ok = bus.key_valid && (w_key_up >= C_ASCII_UA) && (w_key_up <= C_ASCII_UZ);
        for (int i = 0; i < SLOTS; i++) begin
            w_free[i]     = !slots_q[i].active;
            w_match[i]    = w_key_ok && slots_q[i].active && (slots_q[i].ch == w_key_up);
            w_xs[i]       = slots_q[i].x;
            w_zero_key[i] = 1'b0;
        end
    end

    slot_pick #(.N(SLOTS), .KEY_W(1)) u_free_pick (
        .cand_i  (w_free),
        .key_i   (w_zero_key),
        .found_o (w_free_found),
        .idx_o   (w_free_idx)
    );

    slot_pick #(.N(SLOTS), .KEY_W(9)) u_hit_pick (
        .cand_i  (w_match),
        .key_i   (w_xs),
        .found_o (w_hit_found),
        .idx_o   (w_hit_idx)
    );

    assign w_spawn = bus.frame_tick && (cnt_q == C_CNT_LAST);

    // Hit beats spawn beats move; a freshly freed slot is never the spawn target
    // because the free pick looks only at pre-cycle state.
    always_comb begin
        w_miss_cnt = '0;
        for (int i = 0; i < SLOTS; i++) begin
            logic [9:0] nx;
            nx         = {1'b0, slots_q[i].x} + 10'(slots_q[i].spd);
            slots_d[i] = slots_q[i];
            if (w_hit_found && (w_hit_idx == IDX_W'(i))) begin
                slots_d[i].active = 1'b0;
            end else if (w_spawn && w_free_found && (w_free_idx == IDX_W'(i))) begin
                slots_d[i].active = 1'b1;
                slots_d[i].ch     = bus.gen_ch;
                slots_d[i].x      = bus.gen_x;
                slots_d[i].y      = bus.gen_y;
                slots_d[i].spd    = (bus.gen_speed == 3'd0) ? 3'd1 : bus.gen_speed;
            end else if (bus.frame_tick && slots_q[i].active) begin
                if (nx >= C_X_BOT) begin
                    slots_d[i].active = 1'b0;
                    w_miss_cnt        = w_miss_cnt + MC_W'(1);
                end else begin
                    slots_d[i].x = nx[8:0];
                end
            end
        end
        w_miss_sum = {1'b0, miss_q} + 17'(w_miss_cnt);
        miss_d     = w_miss_sum[16] ? 16'hFFFF : w_miss_sum[15:0];
        score_d    = (w_hit_found && (score_q != 16'hFFFF)) ? (score_q + 16'd1) : score_q;
        cnt_d      = !bus.frame_tick ? cnt_q : ((cnt_q == C_CNT_LAST) ? '0 : (cnt_q + CNT_W'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < SLOTS; i++) slots_q[i] <= '0;
            score_q      <= '0;
            miss_q       <= '0;
            cnt_q        <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            running_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            if (bus.start) begin
                state_q     <= ST_RUN;
                for (int i = 0; i < SLOTS; i++) slots_q[i] <= '0;
                score_q     <= '0;
                miss_q      <= '0;
                cnt_q       <= '0;
                running_q   <= 1'b1;
                game_over_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        slots_q      <= slots_d;
                        score_q      <= score_d;
                        miss_q       <= miss_d;
                        cnt_q        <= cnt_d;
                        hit_pulse_q  <= w_hit_found;
                        miss_pulse_q <= (w_miss_cnt != '0);
                        if (miss_q >= C_MAX_MISS) begin
                            state_q     <= ST_OVER;
                            running_q   <= 1'b0;
                            game_over_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_active  = slots_q[bus.rd_idx].active;
    assign bus.rd_ch      = slots_q[bus.rd_idx].ch;
    assign bus.rd_x       = slots_q[bus.rd_idx].x;
    assign bus.rd_y       = slots_q[bus.rd_idx].y;
    assign bus.score      = score_q;
    assign bus.miss       = miss_q;
    assign bus.running    = running_q;
    assign bus.game_over  = game_over_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_letter_pool.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_letter_pool : directed checks of spawn, move, hit, miss, FSM    |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module tb_letter_pool;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    letter_pool_if #(.SLOTS(8)) bus ();

    letter_pool #(
        .SLOTS        (8),
        .SPAWN_FRAMES (30),
        .X_BOTTOM     (440),
        .MAX_MISS     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sel(input int idx);
        logic [31:0] v;
        v          = idx;
        bus.rd_idx = v[2:0];
        #1;
    endtask

    task automatic chk_act(input string tag, input int idx, input int act);
        sel(idx);
        chk(tag, 32'(bus.rd_active), act);
    endtask

    task automatic chk_slot(input string tag, input int idx, input int act, input int ch, input int x);
        sel(idx);
        chk({tag, "_act"}, 32'(bus.rd_active), act);
        chk({tag, "_ch"},  32'(bus.rd_ch), ch);
        chk({tag, "_x"},   32'(bus.rd_x), x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.frame_tick = 1'b1;
            @(posedge clk); #1;
            bus.frame_tick = 1'b0;
        end
    endtask

    task automatic key(input logic [7:0] a);
        bus.key_valid = 1'b1;
        bus.key_ascii = a;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic tick_key(input logic [7:0] a);
        bus.frame_tick = 1'b1;
        bus.key_valid  = 1'b1;
        bus.key_ascii  = a;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        bus.key_valid  = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic set_gen(input logic [7:0] ch, input logic [2:0] spd, input logic [8:0] x, input logic [9:0] y);
        bus.gen_ch    = ch;
        bus.gen_speed = spd;
        bus.gen_x     = x;
        bus.gen_y     = y;
    endtask

    initial begin
        bus.start = 1'b0; bus.frame_tick = 1'b0; bus.key_valid = 1'b0; bus.key_ascii = 8'h00;
        bus.rd_idx = 3'd0;
        set_gen(8'h00, 3'd0, 9'd0, 10'd0);

        // Reset state
        idle(2);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_game_over", 32'(bus.game_over), 0);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_miss", 32'(bus.miss), 0);
        chk("rst_hit_pulse", 32'(bus.hit_pulse), 0);
        chk("rst_miss_pulse", 32'(bus.miss_pulse), 0);
        chk_slot("rst_s0", 0, 0, 0, 0);
        rst_n = 1'b1;

        // IDLE ignores frame ticks
        set_gen(8'h4B, 3'd3, 9'd0, 10'd120);
        ticks(30);
        chk_act("idle_frozen", 0, 0);
        chk("idle_running", 32'(bus.running), 0);

        // First spawn on the 30th tick, then speed 3 motion
        do_start();
        chk("start_running", 32'(bus.running), 1);
        ticks(29);
        chk_act("pre_spawn_s0", 0, 0);
        ticks(1);
        chk_slot("spawn_s0", 0, 1, 8'h4B, 0);
        chk("spawn_s0_y", 32'(bus.rd_y), 120);
        chk_act("spawn_s1_free", 1, 0);
        ticks(2);
        chk_slot("move_s0", 0, 1, 8'h4B, 6);

        // Speed 0 stored as 1
        set_gen(8'h41, 3'd0, 9'd10, 10'd5);
        ticks(28);
        chk_slot("spd0_spawn", 1, 1, 8'h41, 10);
        chk_slot("s0_after", 0, 1, 8'h4B, 90);
        ticks(3);
        chk_slot("spd0_move", 1, 1, 8'h41, 13);

        // Bottom crossing is a miss
        do_start();
        chk_act("restart_clr", 1, 0);
        chk("restart_score", 32'(bus.score), 0);
        set_gen(8'h4B, 3'd3, 9'd438, 10'd0);
        ticks(30);
        chk_slot("edge_spawn", 0, 1, 8'h4B, 438);
        ticks(1);
        chk_act("miss_s0", 0, 0);
        chk("miss_count", 32'(bus.miss), 1);
        chk("miss_pulse_hi", 32'(bus.miss_pulse), 1);
        idle(1);
        chk("miss_pulse_lo", 32'(bus.miss_pulse), 0);

        // Hit in the same tick beats the miss
        do_start();
        chk("restart_miss", 32'(bus.miss), 0);
        ticks(30);
        tick_key(8'h6B);
        chk("hitmiss_score", 32'(bus.score), 1);
        chk("hitmiss_miss", 32'(bus.miss), 0);
        chk("hitmiss_hit_pulse", 32'(bus.hit_pulse), 1);
        chk("hitmiss_miss_pulse", 32'(bus.miss_pulse), 0);
        chk_act("hitmiss_s0", 0, 0);
        idle(1);
        chk("hit_pulse_lo", 32'(bus.hit_pulse), 0);

        // Largest x wins over lower index
        do_start();
        set_gen(8'h41, 3'd1, 9'd0, 10'd0);   ticks(30);
        set_gen(8'h4B, 3'd1, 9'd0, 10'd0);   ticks(30);
        set_gen(8'h42, 3'd1, 9'd0, 10'd0);   ticks(30);
        set_gen(8'h4B, 3'd1, 9'd200, 10'd0); ticks(30);
        chk_slot("k_s1", 1, 1, 8'h4B, 60);
        chk_slot("k_s3", 3, 1, 8'h4B, 200);
        key(8'h6B);
        chk_act("k_s3_cleared", 3, 0);
        chk_slot("k_s1_kept", 1, 1, 8'h4B, 60);
        chk_slot("k_s0_kept", 0, 1, 8'h41, 90);
        chk("k_score", 32'(bus.score), 1);
        key(8'h31);
        key(8'h7A);
        chk("nomatch_score", 32'(bus.score), 1);

        // Full table: spawn dropped, counter still wraps
        do_start();
        for (int i = 0; i < 8; i++) begin
            set_gen(8'(8'h41 + i), 3'd1, 9'd0, 10'd0);
            ticks(30);
        end
        set_gen(8'h5A, 3'd1, 9'd0, 10'd0);
        ticks(30);
        for (int i = 0; i < 8; i++) chk_slot("full", i, 1, 8'h41 + i, 240 - 30 * i);
        key(8'h63);
        chk_act("full_hit_s2", 2, 0);
        chk("full_score", 32'(bus.score), 1);
        set_gen(8'h59, 3'd1, 9'd5, 10'd0);
        ticks(29);
        chk_act("wrap_no_early", 2, 0);
        ticks(1);
        chk_slot("wrap_respawn", 2, 1, 8'h59, 5);

        // Two simultaneous misses end the game
        do_start();
        set_gen(8'h4B, 3'd1, 9'd409, 10'd0); ticks(30);
        set_gen(8'h4B, 3'd1, 9'd439, 10'd0); ticks(30);
        chk_slot("go_s0", 0, 1, 8'h4B, 439);
        chk_slot("go_s1", 1, 1, 8'h4B, 439);
        ticks(1);
        chk("go_miss", 32'(bus.miss), 2);
        chk("go_miss_pulse", 32'(bus.miss_pulse), 1);
        idle(2);
        chk("go_running", 32'(bus.running), 0);
        chk("go_game_over", 32'(bus.game_over), 1);
        set_gen(8'h41, 3'd1, 9'd0, 10'd0);
        ticks(30);
        key(8'h6B);
        chk_act("over_frozen_s0", 0, 0);
        chk("over_miss", 32'(bus.miss), 2);
        chk("over_score", 32'(bus.score), 0);
        do_start();
        chk("rerun_running", 32'(bus.running), 1);
        chk("rerun_game_over", 32'(bus.game_over), 0);
        chk("rerun_miss", 32'(bus.miss), 0);
        chk_slot("rerun_s1", 1, 0, 0, 0);

        // Asynchronous reset mid-run
        set_gen(8'h4B, 3'd1, 9'd0, 10'd0);
        ticks(30);
        key(8'h4B);
        chk("pre_rst_score", 32'(bus.score), 1);
        ticks(30);
        chk_act("pre_rst_s0", 0, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_running", 32'(bus.running), 0);
        chk("async_score", 32'(bus.score), 0);
        chk_act("async_s0", 0, 0);
        idle(1);
        rst_n = 1'b1;
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
